imem_loader: RTL

Boot-time writer for the instruction memory; the CPU core only ever reads this memory. It receives a byte stream over a valid/ready handshake, assembles 16-bit instructions (high byte first), and writes them to consecutive instruction-memory addresses from 0. It holds the CPU in reset until a checksummed image has loaded, then releases it.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_timeout.sv | 30 +++
 rtl/imem_loader.sv | 106 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/imem_loader_byte_timeout.sv
// Idle-cycle counter between stream bytes; TIMEOUT=0 never expires.
module byte_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // Saturates at the limit so expired stays high until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a checksummed byte stream into 16-bit words,
// writes them from address 0 and holds the CPU in reset until it is good.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int WORD_BITS = 8 * BYTES_PER_WORD;
  localparam logic [ADDR_W:0] WC_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [ADDR_W:0] word_cnt;
  logic [7:0]      xor_acc;
  logic            accept, last_word, len_ok, chk_ok, restart;
  logic            to_en, to_clr, expired;

  assign accept    = in_valid && in_ready;
  assign last_word = (words_loaded + WC_ONE) == word_cnt;
  assign len_ok    = (int'(in_data) + 1) <= DEPTH;
  assign chk_ok    = in_data == xor_acc;
  assign restart   = start && (state == IDLE || state == DONE || state == ERR);
  assign to_en     = state inside {HI, LO, CHK};
  assign to_clr    = accept || !to_en;

  byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (to_clr),
    .en      (to_en),
    .expired (expired)
  );

  // An accepted byte wins over a timeout expiring in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEN;
      LEN:     if (accept) state_nxt = len_ok ? HI : ERR;
      HI:      if (accept) state_nxt = LO;
               else if (expired) state_nxt = ERR;
      LO:      if (accept) state_nxt = WRITE;
               else if (expired) state_nxt = ERR;
      WRITE:   state_nxt = last_word ? CHK : HI;
      CHK:     if (accept) state_nxt = chk_ok ? DONE : ERR;
               else if (expired) state_nxt = ERR;
      DONE:    if (start) state_nxt = LEN;
      ERR:     if (start) state_nxt = LEN;
      default: state_nxt = IDLE;
    endcase
  end

  // The write strobe lags WRITE by one edge; address and data stay stable
  // through it because the next high byte can only land at its closing edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      word_cnt     <= '0;
      xor_acc      <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= state_nxt inside {LEN, HI, LO, CHK};
      done     <= state_nxt == DONE;
      error    <= state_nxt == ERR;
      cpu_hold <= state_nxt != DONE;
      mem_we   <= state == WRITE;
      if (accept && state != CHK) xor_acc <= xor_acc ^ in_data;
      if (accept && state == LEN) word_cnt <= (ADDR_W + 1)'(in_data) + WC_ONE;
      if (accept && state == HI) mem_wdata[WORD_BITS-1:8] <= in_data;
      if (accept && state == LO) mem_wdata[7:0] <= in_data;
      if (state == WRITE) words_loaded <= words_loaded + WC_ONE;
      if (mem_we && words_loaded != word_cnt) mem_addr <= mem_addr + ADDR_W'(1);
      if (restart) begin
        words_loaded <= '0;
        xor_acc      <= '0;
        mem_addr     <= '0;
      end
    end
  end

endmodule
